// File: rtl/disp_flip_ctrl.sv
// Display start-up and tear-free frame-buffer flip controller; flips are applied only at VBLANK.
// Define DISP_FRAME_CNT_EN to build the serviced-blank counter on frame_cnt (otherwise tied to 0).
module disp_flip_ctrl #(
    parameter int unsigned          ADDR_W     = 30,
    parameter int unsigned          NUM_BUF    = 2,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = 30'h10a64580,
    parameter logic [ADDR_W-1:0]    BUF_STRIDE = 30'h00096000,
    localparam int unsigned         IDX_W      = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              VBLANK,
    output logic              CLRVBLNK,
    output logic [ADDR_W-1:0] DISPADDR,
    output logic              DISPON,
    input  logic              disp_en,
    input  logic              flip_req,
    input  logic [IDX_W-1:0]  flip_idx,
    output logic              flip_ready,
    output logic              flip_err,
    output logic              flip_done,
    output logic [IDX_W-1:0]  disp_idx,
    output logic [15:0]       frame_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StWaitFirst = 3'd1,
        StRun       = 3'd2,
        StClear     = 3'd3
    } state_e;

    localparam logic [IDX_W:0] NumBufCmp = (IDX_W + 1)'(NUM_BUF);

    state_e            state_q;
    logic              pending;
    logic [IDX_W-1:0]  pend_idx;
    logic [ADDR_W-1:0] flip_addr;
    logic              take_req;
    logic              idx_ok;

    assign flip_ready = ~pending;
    assign take_req   = flip_req & ~pending;
    assign idx_ok     = {1'b0, flip_idx} < NumBufCmp;
    assign flip_addr  = BASE_ADDR + ADDR_W'(pend_idx) * BUF_STRIDE;
    assign state      = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StInit;
            CLRVBLNK  <= 1'b1;
            DISPADDR  <= '0;
            DISPON    <= 1'b0;
            disp_idx  <= '0;
            pending   <= 1'b0;
            pend_idx  <= '0;
            flip_err  <= 1'b0;
            flip_done <= 1'b0;
        end else begin
            flip_done <= 1'b0;
            flip_err  <= 1'b0;
            case (state_q)
                StInit: begin
                    CLRVBLNK <= 1'b0;
                    state_q  <= StWaitFirst;
                end
                StWaitFirst: begin
                    if (VBLANK) begin
                        DISPADDR <= BASE_ADDR;
                        DISPON   <= disp_en;
                        disp_idx <= '0;
                        CLRVBLNK <= 1'b1;
                        state_q  <= StClear;
                    end
                end
                StRun: begin
                    if (VBLANK) begin
                        if (pending) begin
                            DISPADDR  <= flip_addr;
                            disp_idx  <= pend_idx;
                            pending   <= 1'b0;
                            flip_done <= 1'b1;
                        end
                        DISPON   <= disp_en;
                        CLRVBLNK <= 1'b1;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    if (!VBLANK) begin
                        CLRVBLNK <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                default: state_q <= StInit;
            endcase
            // take_req implies !pending, so this never collides with the clear above
            if (take_req) begin
                if (idx_ok) begin
                    pending  <= 1'b1;
                    pend_idx <= flip_idx;
                end else begin
                    flip_err <= 1'b1;
                end
            end
        end
    end

`ifdef DISP_FRAME_CNT_EN
    logic [15:0] frame_q;
    logic        blank_served;

    assign blank_served = VBLANK & ((state_q == StWaitFirst) | (state_q == StRun));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else if (blank_served) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_disp_flip_ctrl.sv
// Bench for disp_flip_ctrl: directed start-up/flip scenarios with literal checks, then random
// traffic compared every cycle against a behavioural model. Uses NUM_BUF=3 so idx 3 is rejectable.
module tb_disp_flip_ctrl;

    localparam int          NB   = 3;
    localparam int          IW   = 2;
    localparam logic [29:0] BASE = 30'h10a64580;
`ifdef DISP_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          VBLANK;
    logic          CLRVBLNK;
    logic [29:0]   DISPADDR;
    logic          DISPON;
    logic          disp_en;
    logic          flip_req;
    logic [IW-1:0] flip_idx;
    logic          flip_ready;
    logic          flip_err;
    logic          flip_done;
    logic [IW-1:0] disp_idx;
    logic [15:0]   frame_cnt;
    logic [2:0]    state;

    disp_flip_ctrl #(
        .ADDR_W    (30),
        .NUM_BUF   (NB),
        .BASE_ADDR (30'h10a64580),
        .BUF_STRIDE(30'h00096000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .VBLANK    (VBLANK),
        .CLRVBLNK  (CLRVBLNK),
        .DISPADDR  (DISPADDR),
        .DISPON    (DISPON),
        .disp_en   (disp_en),
        .flip_req  (flip_req),
        .flip_idx  (flip_idx),
        .flip_ready(flip_ready),
        .flip_err  (flip_err),
        .flip_done (flip_done),
        .disp_idx  (disp_idx),
        .frame_cnt (frame_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase flags rather than a state register
    bit          m_init, m_started, m_clearing, m_pending;
    int          m_pidx, m_idx;
    logic [29:0] m_addr;
    bit          m_on, m_clr, m_done, m_err;
    int unsigned m_cnt;

    function automatic logic [29:0] buf_addr(input int i);
        longint a;
        a = 64'h10a64580 + longint'(i) * 64'h96000;
        return a[29:0];
    endfunction

    task automatic model_reset();
        m_init = 1; m_started = 0; m_clearing = 0; m_pending = 0;
        m_pidx = 0; m_idx = 0; m_addr = '0; m_on = 0; m_clr = 1;
        m_done = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit vb, input bit en, input bit req, input int idx);
        bit accept;
        accept = req && !m_pending;
        m_done = 0;
        m_err  = 0;
        if (m_init) begin
            m_clr  = 0;
            m_init = 0;
        end else if (!m_started) begin
            if (vb) begin
                m_addr = BASE; m_on = en; m_idx = 0; m_clr = 1;
                m_started = 1; m_clearing = 1; m_cnt = (m_cnt + 1) % 65536;
            end
        end else if (m_clearing) begin
            if (!vb) begin
                m_clr = 0; m_clearing = 0;
            end
        end else if (vb) begin
            if (m_pending) begin
                m_addr = buf_addr(m_pidx); m_idx = m_pidx; m_pending = 0; m_done = 1;
            end
            m_on = en; m_clr = 1; m_clearing = 1; m_cnt = (m_cnt + 1) % 65536;
        end
        if (accept) begin
            if (idx < NB) begin
                m_pending = 1; m_pidx = idx;
            end else begin
                m_err = 1;
            end
        end
    endtask

    function automatic int model_state();
        if (m_init) return 0;
        if (!m_started) return 1;
        return m_clearing ? 3 : 2;
    endfunction

    // Compare process: model advances on each edge, DUT outputs sampled 1 time unit later
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step(VBLANK, disp_en, flip_req, int'(flip_idx));
            #1;
            check("m_CLRVBLNK", CLRVBLNK, m_clr);
            check("m_DISPADDR", DISPADDR, m_addr);
            check("m_DISPON", DISPON, m_on);
            check("m_flip_ready", flip_ready, !m_pending);
            check("m_flip_err", flip_err, m_err);
            check("m_flip_done", flip_done, m_done);
            check("m_disp_idx", disp_idx, m_idx);
            check("m_frame_cnt", frame_cnt, CNT_EN ? m_cnt : 0);
            check("m_state", state, model_state());
        end
    end

    // One cycle of stimulus; the display IP's sticky flag is cleared while CLRVBLNK is high
    task automatic cyc(input bit set_vb, input bit req, input logic [IW-1:0] idx);
        @(negedge clk);
        if (CLRVBLNK) VBLANK = 1'b0;
        else if (set_vb) VBLANK = 1'b1;
        flip_req = req;
        flip_idx = idx;
    endtask

    initial begin
        rst = 1'b1; VBLANK = 1'b0; disp_en = 1'b1; flip_req = 1'b0; flip_idx = '0;
        #2 rst = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("rst_CLRVBLNK", CLRVBLNK, 1);
        check("rst_DISPADDR", DISPADDR, 0);
        check("rst_DISPON", DISPON, 0);
        check("rst_flip_ready", flip_ready, 1);
        check("rst_state", state, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0);
            check("wait_CLRVBLNK", CLRVBLNK, 0);
            check("wait_DISPON", DISPON, 0);
            check("wait_state", state, 1);
        end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("first_DISPADDR", DISPADDR, 30'h10a64580);
        check("first_DISPON", DISPON, 1);
        check("first_CLRVBLNK", CLRVBLNK, 1);
        check("first_state", state, 3);
        check("first_frame_cnt", frame_cnt, CNT_EN ? 1 : 0);
        cyc(0, 0, 0);
        check("run_state", state, 2);
        check("run_CLRVBLNK", CLRVBLNK, 0);

        // Flip to buffer 1
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        check("flip1_ready_low", flip_ready, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("flip1_done", flip_done, 1);
        check("flip1_DISPADDR", DISPADDR, 30'h10AFA580);
        check("flip1_disp_idx", disp_idx, 1);
        check("flip1_ready", flip_ready, 1);
        cyc(0, 0, 0);
        check("flip1_done_end", flip_done, 0);

        // Out-of-range index is rejected
        cyc(0, 1, 3);
        cyc(0, 0, 0);
        check("err_pulse", flip_err, 1);
        check("err_ready", flip_ready, 1);
        cyc(0, 0, 0);
        check("err_pulse_end", flip_err, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("err_DISPADDR", DISPADDR, 30'h10AFA580);
        check("err_no_done", flip_done, 0);
        cyc(0, 0, 0);

        // Second request while one is pending is ignored
        cyc(0, 1, 2);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("ign_ready", flip_ready, 0);
        check("ign_no_err", flip_err, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("ign_DISPADDR", DISPADDR, 30'h10B90580);
        check("ign_disp_idx", disp_idx, 2);
        check("ign_done", flip_done, 1);
        cyc(0, 0, 0);
        check("ign_ready_back", flip_ready, 1);

        // Request in the same cycle as a serviced blank waits for the next blank
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        check("sim_no_done", flip_done, 0);
        check("sim_pending", flip_ready, 0);
        check("sim_state", state, 3);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("sim_done", flip_done, 1);
        check("sim_DISPADDR", DISPADDR, 30'h10a64580);
        cyc(0, 0, 0);

        // Reset while in CLEAR with a flip pending
        cyc(1, 1, 1);
        @(negedge clk);
        check("pre_rst_state", state, 3);
        check("pre_rst_pending", flip_ready, 0);
        if (CLRVBLNK) VBLANK = 1'b0;
        flip_req = 1'b0;
        rst = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_CLRVBLNK", CLRVBLNK, 1);
        check("async_DISPADDR", DISPADDR, 0);
        check("async_DISPON", DISPON, 0);
        check("async_ready", flip_ready, 1);
        check("async_frame_cnt", frame_cnt, 0);
        cyc(0, 0, 0);
        rst = 1'b1;
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("restart_DISPADDR", DISPADDR, 30'h10a64580);
        check("restart_no_done", flip_done, 0);
        check("restart_ready", flip_ready, 1);
        check("restart_frame_cnt", frame_cnt, CNT_EN ? 1 : 0);
        cyc(0, 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, IW'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) disp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                cyc(0, 0, 0);
                rst = 1'b1;
            end
        end

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_flip_ctrl.md
Name: disp_flip_ctrl

Overview:
- Parametrised display start-up and frame-buffer flip controller; successor to the single-address display setter.
- Brings the display IP out of reset and clears its sticky VBLANK flag.
- Programs the display start address and enables scan-out.
- Thereafter performs tear-free page flips among NUM_BUF frame buffers, applied only at vertical blank, through a request/ready handshake from the CPU-side register block.

Parameters:
ADDR_W, 30, width of DISPADDR and of the address arithmetic
NUM_BUF, 2, number of frame buffers (1..16)
BASE_ADDR, 30'h10a64580, start address of buffer 0
BUF_STRIDE, 30'h00096000, address distance between consecutive buffers
IDX_W, derived = max(1, clog2(NUM_BUF)), buffer index width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
VBLANK  in  1  sticky vertical-blank flag from display IP; stays 1 until cleared
CLRVBLNK  out  1  clear request to display IP; while 1 the IP drops VBLANK
DISPADDR  out  ADDR_W  frame start address to display IP
DISPON  out  1  display enable to display IP
disp_en  in  1  requested display enable, sampled only at serviced blanks
flip_req  in  1  flip request strobe
flip_idx  in  IDX_W  target buffer index for flip_req
flip_ready  out  1  1 = no flip pending, request will be accepted
flip_err  out  1  one-cycle pulse: request rejected (index out of range)
flip_done  out  1  one-cycle pulse: flip applied to DISPADDR
disp_idx  out  IDX_W  buffer currently displayed
frame_cnt  out  16  serviced-blank counter (see Optional Feature)
state  out  3  FSM state, debug

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, CLRVBLNK=1, DISPADDR=0, DISPON=0, disp_idx=0, pending=0, flip_ready=1, flip_err=0, flip_done=0, frame_cnt=0.
- FSM encoding: INIT=0, WAIT_FIRST=1, RUN=2, CLEAR=3; codes 4..7 go to INIT.
- INIT: CLRVBLNK<=0, go to WAIT_FIRST.
- WAIT_FIRST: hold until VBLANK=1, then:
  - DISPADDR<=BASE_ADDR; DISPON<=disp_en; disp_idx<=0; CLRVBLNK<=1; go to CLEAR.
  - flip_done is not pulsed.
- RUN: when VBLANK=1, service the blank:
  - If pending: DISPADDR<=addr(pend_idx); disp_idx<=pend_idx; pending<=0; flip_done=1 for exactly one cycle.
  - DISPON<=disp_en in all cases.
  - CLRVBLNK<=1; go to CLEAR.
- CLEAR: hold CLRVBLNK=1 until VBLANK=0 is sampled; then CLRVBLNK<=0 and go to RUN. Minimum 2 cycles from the blank to RUN.
- Address arithmetic: addr(i) = BASE_ADDR + i*BUF_STRIDE, computed at ADDR_W bits, wraps modulo 2^ADDR_W.
- Handshake:
  - flip_ready = !pending.
  - A request is taken when flip_req=1 and flip_ready=1, in any state.
  - flip_idx < NUM_BUF: pend_idx<=flip_idx; pending<=1 (flip_ready drops the next cycle).
  - flip_idx >= NUM_BUF: no pending; flip_err pulses one cycle.
  - flip_req while flip_ready=0: ignored, no error.
- Simultaneous request and blank service in the same RUN cycle: the request is latched but not applied; it waits for the next blank.
- Flip to the already displayed index: still applied; flip_done pulses, DISPADDR unchanged.
- Pending request during WAIT_FIRST: kept and applied at the first blank serviced in RUN.
- Reset asserted mid-operation: immediate return to reset values, start-up sequence restarts, pending flip discarded.

Optional Feature:
- Macro: DISP_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 (wrapping 16'hFFFF->0) at every serviced blank, including the first.
- Undefined: frame_cnt is constant 0 and no counter register is built.

Test Plan:
- Reset, hold VBLANK=0 for 10 cycles, then VBLANK=1 with disp_en=1:
  - During the wait: CLRVBLNK 1 then 0, DISPON=0.
  - After the blank: DISPADDR=30'h10a64580, DISPON=1, CLRVBLNK=1 until the model drops VBLANK, then state=RUN.
- In RUN, flip_req with flip_idx=1:
  - flip_ready=0 the next cycle.
  - At the next VBLANK: DISPADDR=30'h10AFA580, disp_idx=1, flip_done one pulse, flip_ready=1.
- flip_idx=2 with NUM_BUF=2 -> flip_err one pulse, flip_ready stays 1, DISPADDR unchanged after the next blank.
- Second flip_req (idx=0) while idx=1 is pending -> ignored; only idx 1 is applied and only one flip_done pulse occurs.
- flip_req in the same cycle RUN sees VBLANK=1 -> no flip_done on that blank; flip applied at the following blank.
- rst pulsed low while in CLEAR with a flip pending -> outputs return to reset values immediately; after restart DISPADDR=BASE_ADDR, no flip_done; with DISP_FRAME_CNT_EN, frame_cnt=1 after the first blank.
